// File: rtl/dmem_arbiter.sv
// dmem_arbiter: two-port data-memory arbiter with lock ownership and misalignment rejection.
// Build option: define DMEM_ARB_ROUND_ROBIN_EN for round-robin contention (default fixed priority).
module dmem_arbiter #(
    parameter int MAX_WAIT = 8
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        p0_req,
    input  logic        p0_we,
    input  logic        p0_lock,
    input  logic [31:0] p0_addr,
    input  logic [2:0]  p0_rwtype,
    input  logic [31:0] p0_wdata,
    output logic        p0_gnt,
    output logic        p0_rvalid,
    output logic [31:0] p0_rdata,
    output logic        p0_err,
    input  logic        p1_req,
    input  logic        p1_we,
    input  logic        p1_lock,
    input  logic [31:0] p1_addr,
    input  logic [2:0]  p1_rwtype,
    input  logic [31:0] p1_wdata,
    output logic        p1_gnt,
    output logic        p1_rvalid,
    output logic [31:0] p1_rdata,
    output logic        p1_err,
    output logic        mem_wen,
    output logic        mem_ren,
    output logic [31:0] mem_addr,
    output logic [2:0]  mem_rwtype,
    output logic [31:0] mem_wdata,
    input  logic [31:0] mem_rdata
);

    localparam int WW = $clog2(MAX_WAIT + 1);
`ifdef DMEM_ARB_ROUND_ROBIN_EN
    localparam bit RR_EN = 1'b1;
`else
    localparam bit RR_EN = 1'b0;
`endif

    typedef enum logic [1:0] {ARB, LOCK0, LOCK1} state_e;

    state_e        state_q, state_d;
    logic          ptr_q, ptr_d;
    logic [WW-1:0] wait_q, wait_d;
    logic [1:0]    rvalid_q, rvalid_d;
    logic [1:0]    err_q, err_d;
    logic [31:0]   rdata0_q, rdata0_d;
    logic [31:0]   rdata1_q, rdata1_d;
    logic          gnt0, gnt1;
    logic          mis0, mis1;
    logic          win1;

    // size 11 is reserved and always rejected
    function automatic logic misaligned(input logic [1:0] size,
                                        input logic [1:0] lsb);
        logic bad;
        case (size)
            2'b00:   bad = 1'b0;
            2'b01:   bad = lsb[0];
            2'b10:   bad = |lsb;
            default: bad = 1'b1;
        endcase
        return bad;
    endfunction

    assign mis0 = misaligned(p0_rwtype[1:0], p0_addr[1:0]);
    assign mis1 = misaligned(p1_rwtype[1:0], p1_addr[1:0]);

    // port 1 wins contention on starvation (fixed) or when it was not last served (round robin)
    assign win1 = (!RR_EN && (wait_q == WW'(MAX_WAIT))) || (RR_EN && !ptr_q);

    // grant decision: lock owner only, otherwise arbitrate; nothing during reset
    always_comb begin
        gnt0 = 1'b0;
        gnt1 = 1'b0;
        if (!reset) begin
            unique case (state_q)
                LOCK0: gnt0 = p0_req;
                LOCK1: gnt1 = p1_req;
                default: begin
                    gnt0 = p0_req && !(p1_req && win1);
                    gnt1 = p1_req && !(p0_req && !win1);
                end
            endcase
        end
    end

    // memory-side mux from the granted port; rejected accesses never touch memory
    always_comb begin
        mem_wen    = 1'b0;
        mem_ren    = 1'b0;
        mem_addr   = '0;
        mem_rwtype = '0;
        mem_wdata  = '0;
        unique case (1'b1)
            gnt0: begin
                mem_wen    = p0_we && !mis0;
                mem_ren    = !p0_we && !mis0;
                mem_addr   = p0_addr;
                mem_rwtype = p0_rwtype;
                mem_wdata  = p0_wdata;
            end
            gnt1: begin
                mem_wen    = p1_we && !mis1;
                mem_ren    = !p1_we && !mis1;
                mem_addr   = p1_addr;
                mem_rwtype = p1_rwtype;
                mem_wdata  = p1_wdata;
            end
            default: ;
        endcase
    end

    // next state: lock ownership, last-grant pointer, starvation counter, responses
    always_comb begin
        state_d  = state_q;
        ptr_d    = ptr_q;
        wait_d   = wait_q;
        rvalid_d = {gnt1 && !p1_we && !mis1, gnt0 && !p0_we && !mis0};
        err_d    = {gnt1 && mis1, gnt0 && mis0};
        rdata0_d = rvalid_d[0] ? mem_rdata : rdata0_q;
        rdata1_d = rvalid_d[1] ? mem_rdata : rdata1_q;
        unique case (state_q)
            ARB: begin
                if (gnt0 && p0_lock) begin
                    state_d = LOCK0;
                end else if (gnt1 && p1_lock) begin
                    state_d = LOCK1;
                end
            end
            LOCK0:   if (!p0_req || !p0_lock) state_d = ARB;
            LOCK1:   if (!p1_req || !p1_lock) state_d = ARB;
            default: state_d = ARB;
        endcase
        if (gnt0) begin
            ptr_d = 1'b0;
        end else if (gnt1) begin
            ptr_d = 1'b1;
        end
        if (RR_EN || !p1_req || gnt1) begin
            wait_d = '0;
        end else if (wait_q != WW'(MAX_WAIT)) begin
            wait_d = wait_q + WW'(1);
        end
    end

    // state registers; reset drops locks and in-flight responses
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= ARB;
            ptr_q    <= 1'b1;
            wait_q   <= '0;
            rvalid_q <= '0;
            err_q    <= '0;
            rdata0_q <= '0;
            rdata1_q <= '0;
        end else begin
            state_q  <= state_d;
            ptr_q    <= ptr_d;
            wait_q   <= wait_d;
            rvalid_q <= rvalid_d;
            err_q    <= err_d;
            rdata0_q <= rdata0_d;
            rdata1_q <= rdata1_d;
        end
    end

    assign p0_gnt    = gnt0;
    assign p1_gnt    = gnt1;
    assign p0_rvalid = rvalid_q[0];
    assign p1_rvalid = rvalid_q[1];
    assign p0_err    = err_q[0];
    assign p1_err    = err_q[1];
    assign p0_rdata  = rdata0_q;
    assign p1_rdata  = rdata1_q;

endmodule

// File: doc/dmem_arbiter.md
DMEM_ARBITER -- requirements
Module: dmem_arbiter

Interface
REQ-001 SHALL have parameter MAX_WAIT, default 8: consecutive cycles port 1 may be denied before a forced grant in fixed-priority mode.
REQ-002 SHALL have ports clk (in, 1, sole clock, rising edge) and reset (in, 1, synchronous, active-high).
REQ-003 SHALL have per-port p inputs pN_req (1, access request), pN_we (1, 1=store), pN_lock (1, hold ownership after this access), pN_addr (32), pN_rwtype (3, [1:0] 00=byte 01=half 10=word, [2]=zero-extend), pN_wdata (32); N=0 (CPU MEM stage), N=1 (DMA/debug).
REQ-004 SHALL have per-port outputs pN_gnt (1, access accepted this cycle), pN_rvalid (1, read response valid), pN_rdata (32), pN_err (1, misaligned access rejected).
REQ-005 SHALL have memory-side outputs mem_wen (1), mem_ren (1), mem_addr (32), mem_rwtype (3), mem_wdata (32), and input mem_rdata (32, combinational read data from the data memory).

Function
REQ-006 SHALL grant at most one port per cycle; pN_gnt is combinational from pN_req, state and arbitration pointer.
REQ-007 SHALL drive mem_* combinationally from the granted port; with no grant, mem_wen=mem_ren=0 and mem_addr/mem_rwtype/mem_wdata=0.
REQ-008 Granted store: mem_wen=1 in grant cycle T; the write commits at the rising edge ending T.
REQ-009 Granted load: mem_ren=1 in T; mem_rdata captured at the edge ending T; pN_rvalid=1 with pN_rdata for exactly cycle T+1.
REQ-010 Misaligned: half with addr[0]=1, or word with addr[1:0]!=00. The request is granted but mem_wen=mem_ren=0, and pN_err=1 for exactly cycle T+1 (pN_rvalid stays 0, even for a load).
REQ-011 rwtype[1:0]=11 SHALL be treated as misaligned, per REQ-010.
REQ-012 FSM states: ARB, LOCK0, LOCK1.
REQ-013 ARB -> LOCKn when port n is granted with pn_lock=1.
REQ-014 In LOCKn, only port n SHALL be granted; the other port waits.
REQ-015 LOCKn -> ARB when port n is granted with pn_lock=0, or when pn_req=0 for a full cycle.
REQ-016 A requester SHALL hold req and attributes stable until gnt; the arbiter does not queue requests.
REQ-017 Back-to-back grants to the same port in consecutive cycles SHALL be allowed; responses pipeline one per cycle.
REQ-018 Wait counter: increments each cycle p1_req=1 and p1_gnt=0 (saturates at MAX_WAIT); clears on p1_gnt or p1_req=0.
REQ-019 Last-grant pointer: updated to the granted port index on every grant.

Reset
REQ-020 On reset=1 at a rising edge: state=ARB, pointer=1 (port 0 wins the first contention), wait counter=0, all pN_rvalid/pN_err=0, all pN_rdata=0.
REQ-021 During reset=1, all pN_gnt=0, mem_wen=0 and mem_ren=0.
REQ-022 In-flight responses SHALL be discarded by reset; a lock SHALL be released by reset.

Configuration
REQ-023 Macro DMEM_ARB_ROUND_ROBIN_EN.
REQ-024 Defined: in ARB with both requesting, the port not equal to the pointer wins; the wait counter is unused, held at 0.
REQ-025 Undefined: in ARB, port 0 wins contention, except that port 1 wins when the wait counter equals MAX_WAIT.

Verification
REQ-026 Reset, then p0 store word 0x12345678 @0x100 -> p0_gnt=1 in same cycle, mem_wen=1, mem_addr=0x100, mem_wdata=0x12345678; next cycle p0_rvalid=0 and p0_err=0.
REQ-027 p1 load byte signed @0x101, mem_rdata=0x0000_80FF -> p1_rvalid=1 next cycle; p1_rdata is whatever the memory returned (sign-extension is the memory's job).
REQ-028 Both req continuously, 10 cycles -> RR build: gnt alternates p0,p1,p0...; fixed build, MAX_WAIT=8: p0 granted 8 cycles, p1 granted in cycle 9.
REQ-029 p0 lock=1 load, then p1 req for 3 cycles while p0 does store lock=0 in 3rd cycle -> p1_gnt=0 throughout; p1 granted the cycle after the unlock.
REQ-030 p0 load word @0x102 -> p0_gnt=1, mem_ren=0, p0_err=1 next cycle; reset asserted in grant cycle of a load -> no rvalid the next cycle, state=ARB.
